// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the iterative 32-bit divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts {rem,quo} left and retires one quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             trial_ok;

  // The shifted remainder can reach 2*divisor-1, so the trial compare needs one extra bit.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial_ok = shifted >= {1'b0, divisor_mag};
  assign diff     = shifted[WIDTH-1:0] - divisor_mag;

  assign rem_next = trial_ok ? diff : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], trial_ok};

endmodule

// File: rtl/seq_divider_32b.sv
// Iterative signed/unsigned 32-bit divider: one quotient bit per clock, start/ready/done handshake.
module seq_divider_32b
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state, state_nxt;
  logic             accept;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] rem, quo, divisor_mag, dividend_raw;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic             q_neg, r_neg, div0;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Control and result registers; results stay visible until the next FIX overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (accept)              cnt <= '0;
      else if (state == CALC)  cnt <= cnt + 1'b1;
      if (state == FIX) begin
        div_by_zero <= div0;
        if (div0) begin
          quotient  <= '1;
          remainder <= dividend_raw;
        end else begin
          quotient  <= q_neg ? -quo : quo;
          remainder <= r_neg ? -rem : rem;
        end
      end
    end
  end

  // NOTE: working datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      quo          <= (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
      divisor_mag  <= (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
      rem          <= '0;
      q_neg        <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg        <= signed_op & dividend[WIDTH-1];
      div0         <= (divisor == '0);
      dividend_raw <= dividend;
    end else if (state == CALC) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem),
    .quo         (quo),
    .divisor_mag (divisor_mag),
    .rem_next    (rem_next),
    .quo_next    (quo_next)
  );

endmodule

// File: tb/tb_seq_divider_32b.sv
// Self-checking bench for seq_divider_32b: directed vector table plus handshake and reset sequences.
module tb_seq_divider_32b;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_divider_32b dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one op (caller ensures ready=1) and returns the cycle index of the done cycle,
  // counting the cycle in which start is accepted as cycle 0; -1 if done never arrives.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  int lat;
  int n_done;

  initial begin
    vecs[0]  = '{"u 100/7",          1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[1]  = '{"s -100/7",         1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{"s 100/-7",         1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
    vecs[3]  = '{"s -100/-7",        1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{"s 5/0",            1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
    vecs[5]  = '{"u 1000000/3",      1'b0, 32'd1000000,  32'd3,        32'd333333,   32'd1,        1'b0};
    vecs[6]  = '{"s ovf",            1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    vecs[7]  = '{"u max/1",          1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[8]  = '{"s -5/0",           1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    vecs[9]  = '{"u max/max",        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vecs[10] = '{"u 8000_0000/max",  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[11] = '{"u 7/100",          1'b0, 32'd7,        32'd100,      32'd0,        32'd7,        1'b0};
    vecs[12] = '{"s -1/2",           1'b1, 32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[13] = '{"u deadbeef/16",    1'b0, 32'hDEADBEEF, 32'd16,       32'h0DEADBEE, 32'hF,        1'b0};
    vecs[14] = '{"s -7/2",           1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    rst = 1'b0;

    check("reset ready",     {31'b0, ready},       32'd1);
    check("reset done",      {31'b0, done},        32'd0);
    check("reset quotient",  quotient,             32'd0);
    check("reset remainder", remainder,            32'd0);
    check("reset dz",        {31'b0, div_by_zero}, 32'd0);

    // Table vectors, each launched in the done cycle of the previous op (back-to-back).
    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, " latency"}, lat, 34);
      check({vecs[i].name, " quotient"}, quotient, vecs[i].q);
      check({vecs[i].name, " remainder"}, remainder, vecs[i].r);
      check({vecs[i].name, " dz"}, {31'b0, div_by_zero}, {31'b0, vecs[i].dz});
    end

    // done is a single-cycle pulse and results hold afterwards.
    tick();
    check("done pulse width", {31'b0, done}, 32'd0);
    check("ready in idle", {31'b0, ready}, 32'd1);
    check("hold quotient", quotient, 32'hFFFFFFFD);

    // start pulsed at cycle 10 of a busy op is ignored.
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    check("busy ready", {31'b0, ready}, 32'd0);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 11; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    check("ignored start latency", lat, 34);
    check("ignored start quotient", quotient, 32'd14);
    check("ignored start remainder", remainder, 32'd2);

    // Start held in the done cycle: prior results visible now, second op done 34 cycles later.
    start = 1'b1; signed_op = 1'b1; dividend = 32'hFFFFFF9C; divisor = 32'd7;
    tick();
    start = 1'b0;
    check("b2b old quotient", quotient, 32'd14);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    check("b2b latency", lat, 34);
    check("b2b quotient", quotient, 32'hFFFFFFF2);
    check("b2b remainder", remainder, 32'hFFFFFFFE);

    // Reset mid-CALC, asserted together with start: reset wins, in-flight op is dropped.
    start = 1'b1; signed_op = 1'b1; dividend = 32'd5; divisor = 32'd0;
    tick();
    start = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("mid rst ready",     {31'b0, ready},       32'd1);
    check("mid rst done",      {31'b0, done},        32'd0);
    check("mid rst quotient",  quotient,             32'd0);
    check("mid rst remainder", remainder,            32'd0);
    check("mid rst dz",        {31'b0, div_by_zero}, 32'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) n_done++;
    end
    check("aborted op done count", n_done, 0);

    do_op(1'b0, 32'd9, 32'd3, lat);
    check("post rst latency", lat, 34);
    check("post rst quotient", quotient, 32'd3);
    check("post rst remainder", remainder, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
